// File: rtl/tone_detector.sv
// Tone detector: measures rise-to-rise period and high time of an asynchronous
// square/PWM input, flags tone presence and reports tone loss after a timeout.
module tone_detector #(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int CNT_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 10,
    parameter int MIN_PERIOD     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 active,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] TMO_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic                 sig_meta, sig_s, sig_d;
    logic                 rise;
    logic                 start, take, tmo_hit;
    logic [CNT_WIDTH-1:0] cnt, hi_cnt;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
            sig_d    <= 1'b0;
        end else begin
            sig_meta <= sig_in;
            sig_s    <= sig_meta;
            sig_d    <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        take     = 1'b0;
        tmo_hit  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = ARM;
                ARM: begin
                    if (rise) begin
                        state_nx = MEASURE;
                        start    = 1'b1;
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still counts as a measurement.
                    if (rise) begin
                        start = 1'b1;
                        take  = (cnt >= MIN_CNT);
                    end else if (cnt >= TMO_CNT) begin
                        tmo_hit  = 1'b1;
                        state_nx = ARM;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            active    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= take;
            timeout <= tmo_hit;
            if (!enable) begin
                cnt    <= '0;
                hi_cnt <= '0;
                active <= 1'b0;
            end else if (start) begin
                cnt    <= CNT_WIDTH'(1);
                hi_cnt <= CNT_WIDTH'(1);
                if (take) begin
                    period    <= cnt;
                    high_time <= hi_cnt;
                    active    <= 1'b1;
                end
            end else if (tmo_hit) begin
                cnt       <= '0;
                hi_cnt    <= '0;
                active    <= 1'b0;
                period    <= '0;
                high_time <= '0;
            end else if (state == MEASURE) begin
                cnt <= cnt + 1'b1;
                if (sig_s) hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: waveform segments drive an edge-level reference
// model that queues expected measurements; a monitor compares DUT strobes.
module tb_tone_detector;

    localparam int CW   = 24;
    localparam int TMO  = 1000;
    localparam int MINP = 4;

    logic          clk = 1'b0;
    logic          reset, enable, sig_in;
    logic [CW-1:0] period, high_time;
    logic          valid, active, timeout;

    tone_detector #(
        .CLOCK_FREQ    (10_000),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TMO),
        .MIN_PERIOD    (MINP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .active   (active),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_tmo;
        int p;
        int h;
        int t;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state, expressed in terms of input edges
    bit armed, prev, en_m;
    int last_rise, hcnt, last_p, last_h;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model(input bit v);
        exp_t e;
        int   p;
        if (en_m && v && !prev) begin
            if (armed) begin
                p = cyc - last_rise;
                if (p >= MINP) begin
                    e = '{0, p, hcnt, cyc + 3};
                    q.push_back(e);
                    last_p = p;
                    last_h = hcnt;
                end
            end
            armed     = 1'b1;
            last_rise = cyc;
            hcnt      = 1;
        end else if (armed && (cyc - last_rise == TMO)) begin
            e = '{1, 0, 0, cyc + 3};
            q.push_back(e);
            armed  = 1'b0;
            last_p = 0;
            last_h = 0;
        end else if (v) begin
            hcnt++;
        end
        prev = v;
    endtask

    task automatic step(input bit v);
        @(posedge clk);
        #1;
        sig_in = v;
        model(v);
    endtask

    task automatic wave(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic set_enable(input bit e);
        enable = e;
        en_m   = e;
        if (!e) armed = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (valid === 1'b1 || timeout === 1'b1)) begin
                if (valid && timeout) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL strobe_overlap: valid and timeout both 1 at cycle %0d", cyc);
                end else if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: valid=%0b timeout=%0b period=%0d at cycle %0d, none expected",
                             valid, timeout, period, cyc);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind_timeout", timeout, e.is_tmo);
                    check("period", period, e.p);
                    check("high_time", high_time, e.h);
                    check("strobe_cycle", cyc, e.t);
                    check("active", active, !e.is_tmo);
                end
            end
        end
    end

    initial begin
        int h, l;
        reset  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        armed = 0; prev = 0; en_m = 0;
        last_rise = 0; hcnt = 0; last_p = 0; last_h = 0;
        #22;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Steady 50/50 and 30/70 waves
        set_enable(1'b1);
        repeat (5) step(1'b0);
        repeat (5) wave(50, 50);
        check("lock_active", active, 1);
        repeat (4) wave(30, 70);

        // Glitch pair inside a 100-cycle wave, then MIN_PERIOD boundary
        wave(50, 50);
        wave(1, 1);
        wave(50, 50);
        check("glitch_period_kept", period, 100);
        wave(1, 2);
        wave(2, 2);
        wave(50, 50);

        // Randomized segments; short ones exercise the glitch filter
        repeat (40) begin
            h = $urandom_range(1, 60);
            l = $urandom_range(1, 60);
            wave(h, l);
        end

        // Rise exactly on the timeout cycle is still measured
        wave(10, TMO - 10);
        wave(50, 50);
        wave(50, 50);

        // Enable dropped mid-period, re-raised after 20 cycles
        repeat (10) step(1'b1);
        set_enable(1'b0);
        repeat (10) step(1'b1);
        check("dis_active", active, 0);
        check("dis_period_held", period, last_p);
        check("dis_high_held", high_time, last_h);
        repeat (10) step(1'b0);
        set_enable(1'b1);
        repeat (10) step(1'b0);
        repeat (3) wave(40, 60);

        // Stop toggling: timeout after TMO cycles without a rise
        wave(50, 50);
        repeat (TMO + 100) step(1'b0);
        check("tmo_active", active, 0);
        check("tmo_period", period, 0);
        check("tmo_high_time", high_time, 0);
        repeat (3) wave(50, 50);

        // One cycle late rise loses to the timeout
        wave(10, TMO - 9);
        repeat (2) wave(50, 50);

        // Stuck high
        repeat (TMO + 100) step(1'b1);
        repeat (20) step(1'b0);
        repeat (3) wave(25, 75);

        // Async reset during MEASURE
        repeat (50) step(1'b1);
        repeat (20) step(1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        armed = 0; last_p = 0; last_h = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) step(1'b0);
        repeat (3) wave(50, 50);

        repeat (10) step(1'b0);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
